branch_control_seq: RTL and testbench

Parametrised hardwired control sequencer for the branch instruction class: brzr, brnz, brpl and brmi. It drives the datapath's bus-select, register-enable and memory strobes through fetch (T0–T2) and branch execute (T3–T6), with a configurable memory-wait length. When the condition fails it can exit early. It replaces hand-sequenced control for branches and sits beside the datapath, taking `IR` and `CON` from it and driving its control inputs.

---
 rtl/branch_control_seq.sv | 94 +++++++++
 tb/tb_branch_control_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_control_seq.sv
// branch_control_seq: hardwired fetch/execute control sequencer for the branch instruction class
module branch_control_seq #(
  parameter int OPCODE_WIDTH = 5,
  parameter logic [OPCODE_WIDTH-1:0] BR_OPCODE = 5'b10010,
  parameter int MEM_WAIT = 0,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int CNT_WIDTH = 16
)(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [31:0]          i_ir,
  input  logic                 i_con,
  output logic                 o_pc_out,
  output logic                 o_mar_in,
  output logic                 o_inc_pc,
  output logic                 o_z_in,
  output logic                 o_read,
  output logic                 o_mdr_in,
  output logic                 o_pc_in,
  output logic                 o_zlo_out,
  output logic                 o_mdr_out,
  output logic                 o_ir_in,
  output logic                 o_gra,
  output logic                 o_r_out,
  output logic                 o_con_in,
  output logic                 o_y_in,
  output logic                 o_c_out,
  output logic                 o_run,
  output logic                 o_illegal,
  output logic                 o_br_taken,
  output logic [CNT_WIDTH-1:0] o_instr_count
);
  localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  typedef enum logic [3:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;
  state_t r_state, w_next;
  logic [WW-1:0] r_wait;
  logic [CNT_WIDTH-1:0] r_count;
  logic w_last, w_br, w_fail, w_end, w_unused_ir;
  // Condition select bits and operand fields belong to the datapath, not to this sequencer.
  assign w_unused_ir = ^i_ir[31-OPCODE_WIDTH:0];
  assign w_last = r_wait == WW'(MEM_WAIT);
  assign w_br = i_ir[31 -: OPCODE_WIDTH] == BR_OPCODE;
  assign w_fail = !i_con && EARLY_EXIT;
  assign w_end = (r_state == S_T4 && w_fail) || r_state == S_T6;
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // T1 memory-wait counter; cleared on every cycle that is not a non-final T1 cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_wait <= '0;
    else r_wait <= (r_state == S_T1 && !w_last) ? r_wait + WW'(1) : '0;
  // Retired-branch counter, wraps naturally
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else if (w_end) r_count <= r_count + CNT_WIDTH'(1);
  // Next-state decode; Stop only matters at instruction end and beats Start there
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = i_start ? S_T0 : S_IDLE;
      S_T0:   w_next = S_T1;
      S_T1:   w_next = w_last ? S_T2 : S_T1;
      S_T2:   w_next = S_T3;
      S_T3:   w_next = w_br ? S_T4 : S_HALT;
      S_T4:   w_next = w_fail ? (i_stop ? S_IDLE : S_T0) : S_T5;
      S_T5:   w_next = S_T6;
      S_T6:   w_next = i_stop ? S_IDLE : S_T0;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end
  assign o_pc_out      = r_state == S_T0 || (r_state == S_T4 && !w_fail);
  assign o_mar_in      = r_state == S_T0;
  assign o_inc_pc      = r_state == S_T0;
  assign o_z_in        = r_state == S_T0 || r_state == S_T5;
  assign o_read        = r_state == S_T1;
  assign o_mdr_in      = r_state == S_T1 && w_last;
  assign o_pc_in       = (r_state == S_T1 && w_last) || (r_state == S_T6 && i_con);
  assign o_zlo_out     = (r_state == S_T1 && w_last) || r_state == S_T6;
  assign o_mdr_out     = r_state == S_T2;
  assign o_ir_in       = r_state == S_T2;
  assign o_gra         = r_state == S_T3 && w_br;
  assign o_r_out       = r_state == S_T3 && w_br;
  assign o_con_in      = r_state == S_T3 && w_br;
  assign o_y_in        = r_state == S_T4 && !w_fail;
  assign o_c_out       = r_state == S_T5;
  assign o_run         = r_state != S_IDLE && r_state != S_HALT;
  assign o_illegal     = r_state == S_HALT;
  assign o_br_taken    = r_state == S_T6 && i_con;
  assign o_instr_count = r_count;
endmodule

// File: tb/tb_branch_control_seq.sv
// tb_branch_control_seq: randomized check of three sequencer configurations against a timeline model
module tb_branch_control_seq;
  logic clk, rst_n, start, stop, con;
  logic [31:0] ir;
  logic [17:0] w_s [3];
  logic [3:0] w_c [3];
  int n_tests, n_fail;
  int m_mode [3], m_pos [3], m_cnt [3];
  logic [17:0] tbl [8] = '{18'b111100000000000100, 18'b000011110000000100, 18'b000000001100000100,
                           18'b000000000011100100, 18'b100000000000010100, 18'b000100000000001100,
                           18'b000000110000000101, 18'b111100000000000100};
  for (genvar g = 0; g < 3; g++) begin : g_dut
    branch_control_seq #(.MEM_WAIT(g == 2 ? 3 : 0), .EARLY_EXIT(g != 1), .CNT_WIDTH(4)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_ir(ir), .i_con(con),
      .o_pc_out(w_s[g][17]), .o_mar_in(w_s[g][16]), .o_inc_pc(w_s[g][15]), .o_z_in(w_s[g][14]),
      .o_read(w_s[g][13]), .o_mdr_in(w_s[g][12]), .o_pc_in(w_s[g][11]), .o_zlo_out(w_s[g][10]),
      .o_mdr_out(w_s[g][9]), .o_ir_in(w_s[g][8]), .o_gra(w_s[g][7]), .o_r_out(w_s[g][6]),
      .o_con_in(w_s[g][5]), .o_y_in(w_s[g][4]), .o_c_out(w_s[g][3]), .o_run(w_s[g][2]),
      .o_illegal(w_s[g][1]), .o_br_taken(w_s[g][0]), .o_instr_count(w_c[g]));
  end
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic int mwf(int k);
    return k == 2 ? 3 : 0;
  endfunction
  function automatic bit eef(int k);
    return k != 1;
  endfunction
  // Expected strobes from the position within the instruction timeline (T0 at 0, T1 spans 1..1+mw)
  function automatic logic [17:0] expv(int k);
    int mw, p;
    logic r, br, fl;
    mw = mwf(k);
    p = m_pos[k];
    r = m_mode[k] == 1;
    br = ir[31:27] == 5'b10010;
    fl = !con && eef(k);
    return {r && (p == 0 || (p == 4 + mw && !fl)), r && p == 0, r && p == 0, r && (p == 0 || p == 5 + mw),
            r && p >= 1 && p <= 1 + mw, r && p == 1 + mw, r && (p == 1 + mw || (p == 6 + mw && con)),
            r && (p == 1 + mw || p == 6 + mw), r && p == 2 + mw, r && p == 2 + mw,
            r && p == 3 + mw && br, r && p == 3 + mw && br, r && p == 3 + mw && br,
            r && p == 4 + mw && !fl, r && p == 5 + mw, r, m_mode[k] == 2, r && p == 6 + mw && con};
  endfunction
  // Model: mode 0 idle, 1 running an instruction, 2 halted
  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 3; k++)
      if (!rst_n) begin
        m_mode[k] <= 0;
        m_pos[k] <= 0;
        m_cnt[k] <= 0;
      end else if (m_mode[k] == 0) begin
        if (start) begin
          m_mode[k] <= 1;
          m_pos[k] <= 0;
        end
      end else if (m_mode[k] == 1) begin
        if (m_pos[k] == 3 + mwf(k) && ir[31:27] != 5'b10010) m_mode[k] <= 2;
        else if ((m_pos[k] == 4 + mwf(k) && !con && eef(k)) || m_pos[k] == 6 + mwf(k)) begin
          m_cnt[k] <= (m_cnt[k] + 1) % 16;
          m_mode[k] <= stop ? 0 : 1;
          m_pos[k] <= 0;
        end else m_pos[k] <= m_pos[k] + 1;
      end
  // Every-cycle comparison of all instances against the model
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      n_tests += 2;
      if (w_s[k] !== expv(k)) begin
        n_fail++;
        $display("FAIL model_strobes dut%0d t=%0t: got %b expected %b", k, $time, w_s[k], expv(k));
      end
      if (w_c[k] !== 4'(m_cnt[k])) begin
        n_fail++;
        $display("FAIL model_count dut%0d t=%0t: got %0d expected %0d", k, $time, w_c[k], m_cnt[k]);
      end
    end
  task automatic chk(string nm, logic [17:0] a, logic [17:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %b expected %b", nm, $time, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic look;
    @(negedge clk);
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 0;
    start = 0;
    stop = 0;
    ir = 0;
    con = 0;
    tick;
    look;
    for (int k = 0; k < 3; k++) begin
      chk("reset_strobes", w_s[k], 18'd0);
      chk("reset_count", 18'(w_c[k]), 18'd0);
    end
    tick;
    rst_n = 1;
    ir = 32'h9300_0019;
    con = 1;
    start = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      look;
      chk("taken_seq", w_s[0], tbl[i]);
      if (i >= 1 && i <= 4) begin
        chk("memwait_read", 18'(w_s[2][13]), 18'd1);
        chk("memwait_mdrin", 18'(w_s[2][12]), 18'(i == 4));
        chk("memwait_pcin", 18'(w_s[2][11]), 18'(i == 4));
      end
    end
    chk("taken_count", 18'(w_c[0]), 18'd1);
    tick;
    con = 0;
    look;
    tick;
    look;
    tick;
    look;
    tick;
    look;
    chk("early_exit_t4", w_s[0], 18'b000000000000000100);
    chk("no_early_t4", w_s[1], tbl[4]);
    tick;
    look;
    chk("early_exit_next_t0", w_s[0], tbl[0]);
    chk("no_early_t5", w_s[1], tbl[5]);
    tick;
    look;
    chk("no_early_t6", w_s[1], 18'b000000010000000100);
    chk("early_exit_count", 18'(w_c[0]), 18'd2);
    chk("no_early_count", 18'(w_c[1]), 18'd1);
    tick;
    rst_n = 0;
    tick;
    rst_n = 1;
    ir = 32'h1800_0000;
    for (int i = 0; i < 5; i++) begin
      tick;
      look;
      if (i == 3) chk("illegal_t3", w_s[0], 18'b000000000000000100);
      if (i == 4) chk("halt", w_s[0], 18'b000000000000000010);
    end
    repeat (3) begin
      tick;
      look;
    end
    chk("halt_ignores_start", w_s[0], 18'b000000000000000010);
    #1 rst_n = 0;
    #1 chk("halt_reset", w_s[0], 18'd0);
    tick;
    start = 0;
    rst_n = 1;
    look;
    chk("idle_after_halt", w_s[0], 18'd0);
    tick;
    ir = 32'h9300_0019;
    con = 1;
    start = 1;
    for (int i = 0; i < 13; i++) begin
      tick;
      look;
    end
    chk("mid_t5", w_s[0], tbl[5]);
    chk("pre_reset_count", 18'(w_c[0]), 18'd1);
    #1 rst_n = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_reset_strobes", w_s[k], 18'd0);
      chk("async_reset_count", 18'(w_c[k]), 18'd0);
    end
    tick;
    rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      tick;
      if (i == 6) stop = 1;
      look;
    end
    chk("stop_t6", w_s[0], tbl[6]);
    tick;
    look;
    chk("stop_idle", w_s[0], 18'd0);
    chk("stop_count", 18'(w_c[0]), 18'd1);
    tick;
    stop = 0;
    look;
    chk("restart_t0", w_s[0], tbl[0]);
    for (int i = 0; i < 4000; i++) begin
      tick;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 59) == 0) rst_n = 0;
      start = $urandom_range(0, 3) != 0;
      stop = $urandom_range(0, 7) == 0;
      con = 1'($urandom_range(0, 1));
      ir = $urandom_range(0, 31) == 0 ? $urandom : {5'b10010, 27'($urandom)};
    end
    tick;
    look;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
